// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
//
// Purpose:
//   Shared constants and helpers for the UART receive FIFO slice. Holds the
//   default character width and queue depth, a constant-evaluable ceiling
//   log2, and the derivation of pointer and occupancy-counter widths. Both
//   uart_rx_fifo and uart_rx_fifo_mem import this package, so the sizing
//   math is defined in one place.
//
// Contents:
//   DEFAULT_DATA_WIDTH  default width of one received character (8)
//   DEFAULT_DEPTH       default number of FIFO entries (16)
//   clog2()             ceiling log2, usable in parameter expressions
//   ptr_width()         bits needed to address DEPTH entries (at least 1)
//   count_width()       bits needed to hold an occupancy of 0..DEPTH
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 16;

  // Ceiling log2. Written as a plain loop so it can be used as a constant
  // function while parameters are being elaborated.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Pointer width. Clamped to one bit so a degenerate depth still yields a
  // legal vector; the FIFO itself requires a depth of at least 2.
  function automatic int ptr_width(input int depth);
    int width;
    width = clog2(depth);
    if (width < 1) begin
      width = 1;
    end
    return width;
  endfunction

  // The counter needs one more bit than the pointers, because it must tell
  // a full queue (DEPTH) apart from an empty one (0).
  function automatic int count_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_mem
//
// Purpose:
//   Storage array for the UART receive FIFO. A DEPTH x DATA_WIDTH register
//   file with one synchronous write port and one asynchronous read port.
//   The asynchronous read gives the parent FIFO its first-word fall-through
//   behaviour: the entry addressed by the read pointer is visible in the
//   same cycle the pointer moves. Contents are not reset; the parent's
//   valid flag hides stale entries from the consumer.
//
// Parameters:
//   DATA_WIDTH  width of one stored character
//   DEPTH       number of entries (power of two, at least 2)
//   ADDR_WIDTH  derived address width, not overridable
//
// Ports:
//   clk      in   system clock, write on the rising edge
//   wr_en    in   write strobe for this cycle
//   wr_addr  in   entry to write
//   wr_data  in   character to store
//   rd_addr  in   entry to read
//   rd_data  out  contents of the entry at rd_addr (combinational)
// ---------------------------------------------------------------------------
module uart_rx_fifo_mem
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: storage only, no reset. A stale entry is never presented
  // as valid, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: unregistered, so the head entry is visible as soon as the
  // read pointer addresses it.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Purpose:
//   Receive-side byte buffer placed directly after the UART receiver. Each
//   character arrives with a one-cycle strobe and is queued in a circular
//   FIFO. The consumer reads the queue through a valid/ready handshake with
//   first-word fall-through. The block reports its fill level, full and
//   empty status, and a sticky overflow flag for characters lost while the
//   queue was full. The receiver cannot be stalled, so a character that
//   arrives while the queue is full and nothing is being popped is dropped.
//
// Optional feature (macro UART_RX_FIFO_THRESH_EN):
//   When this macro is defined, the block gains an Almost_full output that
//   is registered and compares the next Count against the Thresh input.
//   Almost_full changes on the same edge as Count and resets to 0. When the
//   macro is not defined, both ports and their logic are left out.
//
// Parameters:
//   DATA_WIDTH  character width, must match the receiver output
//   DEPTH       number of entries (power of two, at least 2)
//   ADDR_WIDTH  derived pointer width, not overridable
//
// Ports:
//   Clk          in   system clock, rising edge
//   Rst          in   synchronous active-high reset, overrides all inputs
//   Rx_data      in   received character
//   Rx_valid     in   one-cycle strobe qualifying Rx_data
//   Rd_data      out  oldest stored character (head of queue)
//   Rd_valid     out  queue non-empty, Rd_data meaningful
//   Rd_ready     in   consumer accepts Rd_data this cycle
//   Full         out  Count == DEPTH
//   Empty        out  Count == 0
//   Count        out  number of stored entries
//   Overflow     out  sticky flag, a character was dropped
//   Ovf_clr      in   clears Overflow (a drop in the same cycle wins)
//   Thresh       in   almost-full threshold  (UART_RX_FIFO_THRESH_EN only)
//   Almost_full  out  next Count >= Thresh   (UART_RX_FIFO_THRESH_EN only)
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int ADDR_WIDTH = ptr_width(DEPTH)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Rx_data,
  input  logic                  Rx_valid,
  output logic [DATA_WIDTH-1:0] Rd_data,
  output logic                  Rd_valid,
  input  logic                  Rd_ready,
  output logic                  Full,
  output logic                  Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  input  logic                  Ovf_clr
`ifdef UART_RX_FIFO_THRESH_EN
  ,
  input  logic [ADDR_WIDTH:0]   Thresh,
  output logic                  Almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status flags come from the registered count only, so they carry no
  // combinational path from this cycle's inputs.
  assign Full     = (Count == COUNT_FULL);
  assign Empty    = (Count == '0);
  assign Rd_valid = !Empty;

  // A pop needs a valid head. That means a strobe arriving while the queue
  // is empty is a push only, even if Rd_ready is already high. A write to a
  // full queue is still accepted when a pop frees a slot in the same cycle,
  // because the pop's slot is freed on the same edge as the write.
  assign pop  = Rd_valid && Rd_ready;
  assign push = Rx_valid && (!Full || pop);
  assign drop = Rx_valid && Full && !pop;

  // Next occupancy. A push and a pop in the same cycle cancel out.
  always_comb begin
    count_next = Count;
    unique case ({push, pop})
      2'b10:   count_next = Count + COUNT_ONE;
      2'b01:   count_next = Count - COUNT_ONE;
      default: count_next = Count;
    endcase
  end

  // Pointers and count. The pointers are exactly ADDR_WIDTH bits wide and
  // DEPTH is a power of two, so they wrap from DEPTH-1 to 0 on their own.
  // Reset clears everything here on the same edge, even if a push or pop
  // is requested in that cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      Count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      Count <= count_next;
    end
  end

  // Sticky overflow. If a drop and a clear request happen in the same
  // cycle, the set wins, so no lost character can go unreported.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Overflow <= 1'b0;
    end else if (drop) begin
      Overflow <= 1'b1;
    end else if (Ovf_clr) begin
      Overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_THRESH_EN
  // Almost-full compares the next count, so it updates on the same edge as
  // Count. A threshold of zero makes it 1 from the first edge after reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Almost_full <= 1'b0;
    end else begin
      Almost_full <= (count_next >= Thresh);
    end
  end
`endif

  uart_rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (Clk),
    .wr_en   (push && !Rst),
    .wr_addr (wr_ptr),
    .wr_data (Rx_data),
    .rd_addr (rd_ptr),
    .rd_data (Rd_data)
  );

endmodule
